// File: rtl/instr_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_if
//   Bundles the two buses of the instruction fetch stage:
//     - byte-wide instruction memory read port (imem_rd / imem_addr / imem_rdata)
//     - IF/ID output handshake (out_valid / out_ready / instruction_out / pc_out)
//   master : the fetch unit (drives the read strobe/address and the output word)
//   slave  : memory + IF/ID consumer (returns read data, drives out_ready)
// ---------------------------------------------------------------------------
interface instr_fetch_unit_if #(
  parameter int PC_W = 8
) ();

  logic            imem_rd;
  logic [PC_W-1:0] imem_addr;
  logic [7:0]      imem_rdata;

  logic            out_valid;
  logic            out_ready;
  logic [31:0]     instruction_out;
  logic [PC_W-1:0] pc_out;

  modport master (
    output imem_rd,
    output imem_addr,
    input  imem_rdata,
    output out_valid,
    input  out_ready,
    output instruction_out,
    output pc_out
  );

  modport slave (
    input  imem_rd,
    input  imem_addr,
    output imem_rdata,
    input  out_valid,
    output out_ready,
    input  instruction_out,
    input  pc_out
  );

endinterface : instr_fetch_unit_if

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//   Instruction fetch stage feeding the IF/ID register. Holds the PC, reads a
//   32-bit instruction as four little-endian bytes from a byte-wide memory
//   with a fixed one-cycle read latency, and presents {instruction, pc} on a
//   valid/ready handshake. Later stages may redirect the PC at any time.
//
// Ports
//   clk            : clock, all state updates on the rising edge
//   rst_n          : synchronous reset, active-low
//   bus (master)   : imem read port and IF/ID output handshake
//   redirect_valid : taken branch/jump, load redirect_pc
//   redirect_pc    : redirect target, low two bits forced to zero
//   fetch_count    : number of completed output handshakes (wraps)
//
// Timing: RD0 RD1 RD2 RD3 CAP3 HOLD -> out_valid rises 5 cycles after RD0,
// one instruction per 6 cycles when out_ready is held high.
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_unit_if.master  bus,
  input  logic                redirect_valid,
  input  logic [PC_W-1:0]     redirect_pc,
  output logic [CNT_W-1:0]    fetch_count
);

  typedef enum logic [2:0] {
    RD0,
    RD1,
    RD2,
    RD3,
    CAP3,
    HOLD
  } state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q;
  logic [23:0]       asm_q;          // bytes 0..2 of the word being assembled
  logic              out_valid_q;
  logic [31:0]       instr_q;
  logic [PC_W-1:0]   pc_out_q;
  logic [CNT_W-1:0]  fetch_count_q;

  logic              rd_en;
  logic [PC_W-1:0]   addr_off;
  logic              load_out;
  logic              accept;

  // Next-state and per-state controls. Byte k-1 arrives while in RDk because
  // of the one-cycle memory latency; byte 3 arrives in CAP3.
  always_comb begin
    // NOTE: every output of this block is given a default first so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    rd_en    = 1'b0;
    addr_off = '0;
    load_out = 1'b0;
    accept   = 1'b0;

    case (state_q)
      RD0: begin
        rd_en   = 1'b1;
        state_d = RD1;
      end
      RD1: begin
        rd_en    = 1'b1;
        addr_off = PC_W'(1);
        state_d  = RD2;
      end
      RD2: begin
        rd_en    = 1'b1;
        addr_off = PC_W'(2);
        state_d  = RD3;
      end
      RD3: begin
        rd_en    = 1'b1;
        addr_off = PC_W'(3);
        state_d  = CAP3;
      end
      CAP3: begin
        load_out = 1'b1;
        state_d  = HOLD;
      end
      HOLD: begin
        if (out_valid_q && bus.out_ready) begin
          accept  = 1'b1;
          state_d = RD0;
        end
      end
      default: state_d = RD0;
    endcase

    // A redirect restarts the fetch from any state. A handshake that coincides
    // with it in HOLD still completes (accept stays set).
    if (redirect_valid) begin
      state_d = RD0;
    end
  end

  // NOTE: all registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= RD0;
      pc_q          <= RESET_PC;
      asm_q         <= '0;
      out_valid_q   <= 1'b0;
      instr_q       <= '0;
      pc_out_q      <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q <= state_d;

      if (accept) begin
        fetch_count_q <= fetch_count_q + CNT_W'(1);
      end

      if (redirect_valid) begin
        // Partially assembled bytes are abandoned; the byte returned next
        // cycle lands in RD0, which never captures.
        pc_q        <= {redirect_pc[PC_W-1:2], 2'b00};
        out_valid_q <= 1'b0;
      end else begin
        case (state_q)
          RD1:     asm_q[7:0]   <= bus.imem_rdata;
          RD2:     asm_q[15:8]  <= bus.imem_rdata;
          RD3:     asm_q[23:16] <= bus.imem_rdata;
          default: ;
        endcase

        if (load_out) begin
          instr_q     <= {bus.imem_rdata, asm_q};
          pc_out_q    <= pc_q;
          out_valid_q <= 1'b1;
        end

        if (accept) begin
          out_valid_q <= 1'b0;
          pc_q        <= pc_q + PC_W'(4);
        end
      end
    end
  end

  // Read strobe is suppressed while reset is asserted; address shows pc when idle.
  assign bus.imem_rd         = rd_en & rst_n;
  assign bus.imem_addr       = pc_q + addr_off;
  assign bus.out_valid       = out_valid_q;
  assign bus.instruction_out = instr_q;
  assign bus.pc_out          = pc_out_q;
  assign fetch_count         = fetch_count_q;

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Directed and randomized bench for instr_fetch_unit. The byte memory is an
//   array answering one cycle after each strobe (random garbage otherwise).
//   Expected words are assembled from the memory array by address; expected
//   pc and fetch count follow the architectural rules (pc+4 on accept,
//   aligned target on redirect).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  localparam int PC_W  = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             redirect_valid;
  logic [PC_W-1:0]  redirect_pc;
  logic [CNT_W-1:0] fetch_count;

  instr_fetch_unit_if #(.PC_W(PC_W)) bus ();

  instr_fetch_unit #(
    .PC_W    (PC_W),
    .RESET_PC('0),
    .CNT_W   (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .fetch_count   (fetch_count)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];

  // One-cycle-latency byte memory; garbage when not read to expose stale use.
  always @(posedge clk) begin
    if (bus.imem_rd) bus.imem_rdata <= mem[bus.imem_addr];
    else             bus.imem_rdata <= 8'($urandom);
  end

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  exp_pc;
  logic [15:0] exp_fc;
  logic [31:0] held_word;
  int          lat;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [7:0] a);
    logic [7:0] a1, a2, a3;
    a1 = a + 8'd1;
    a2 = a + 8'd2;
    a3 = a + 8'd3;
    return {mem[a3], mem[a2], mem[a1], mem[a]};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  // Counts cycles from the current negedge until out_valid, bounded.
  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!bus.out_valid && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'hA0; mem[3] = 8'h00;

    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    bus.out_ready  = 1'b0;
    exp_pc         = 8'h00;
    exp_fc         = 16'h0;

    // ---- reset state ----
    step(); step();
    check("rst_imem_rd", bus.imem_rd, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_instr", bus.instruction_out, 32'h0);
    check("rst_pc_out", bus.pc_out, 8'h00);
    check("rst_fetch_count", fetch_count, 16'h0);

    // ---- test 1: first fetch, latency, next fetch address ----
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check("t1_rd0_rd", bus.imem_rd, 1'b1);
    check("t1_rd0_addr", bus.imem_addr, 8'h00);
    wait_valid(lat);
    check("t1_latency", lat, 5);
    check("t1_instr", bus.instruction_out, 32'h00A00513);
    check("t1_pc_out", bus.pc_out, 8'h00);
    step();
    exp_fc++; exp_pc += 8'd4;
    check("t1_fc", fetch_count, exp_fc);
    check("t1_valid_drop", bus.out_valid, 1'b0);
    check("t1_next_addr", bus.imem_addr, exp_pc);
    check("t1_next_rd", bus.imem_rd, 1'b1);

    // ---- test 2: throughput and stall in HOLD ----
    bus.out_ready = 1'b0;
    wait_valid(lat);
    check("t2_latency", lat, 5);
    check("t2_instr", bus.instruction_out, word_at(exp_pc));
    check("t2_pc_out", bus.pc_out, exp_pc);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_stall_valid", bus.out_valid, 1'b1);
      check("t2_stall_instr", bus.instruction_out, word_at(exp_pc));
      check("t2_stall_pc_out", bus.pc_out, exp_pc);
      check("t2_stall_rd", bus.imem_rd, 1'b0);
      check("t2_stall_addr", bus.imem_addr, exp_pc);
      check("t2_stall_fc", fetch_count, exp_fc);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    exp_fc++; exp_pc += 8'd4;
    check("t2_fc", fetch_count, exp_fc);
    check("t2_next_addr", bus.imem_addr, exp_pc);

    // ---- test 3: redirect during RD2 ----
    step(); step();
    check("t3_rd2_addr", bus.imem_addr, exp_pc + 8'd2);
    redirect_valid = 1'b1;
    redirect_pc    = 8'h22;
    step();
    redirect_valid = 1'b0;
    exp_pc = 8'h20;
    check("t3_redir_rd", bus.imem_rd, 1'b1);
    check("t3_redir_addr", bus.imem_addr, 8'h20);
    wait_valid(lat);
    check("t3_latency", lat, 5);
    check("t3_instr", bus.instruction_out, word_at(8'h20));
    check("t3_pc_out", bus.pc_out, 8'h20);
    check("t3_fc_hold", fetch_count, exp_fc);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    exp_fc++; exp_pc += 8'd4;
    check("t3_fc", fetch_count, exp_fc);
    check("t3_next_addr", bus.imem_addr, exp_pc);

    // ---- test 4: wrap-around at top of address space ----
    redirect_valid = 1'b1;
    redirect_pc    = 8'hFE;
    step();
    redirect_valid = 1'b0;
    exp_pc = 8'hFC;
    check("t4_addr0", bus.imem_addr, 8'hFC);
    step(); check("t4_addr1", bus.imem_addr, 8'hFD);
    step(); check("t4_addr2", bus.imem_addr, 8'hFE);
    step(); check("t4_addr3", bus.imem_addr, 8'hFF);
    step(); check("t4_cap_rd", bus.imem_rd, 1'b0);
    step();
    check("t4_valid", bus.out_valid, 1'b1);
    check("t4_instr", bus.instruction_out, word_at(8'hFC));
    check("t4_pc_out", bus.pc_out, 8'hFC);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    exp_fc++; exp_pc += 8'd4;
    check("t4_wrap_addr", bus.imem_addr, 8'h00);
    check("t4_fc", fetch_count, exp_fc);

    // ---- test 6: redirect together with handshake in HOLD ----
    wait_valid(lat);
    check("t6_latency", lat, 5);
    check("t6_instr", bus.instruction_out, word_at(exp_pc));
    redirect_valid = 1'b1;
    redirect_pc    = 8'h40;
    bus.out_ready  = 1'b1;
    step();
    redirect_valid = 1'b0;
    bus.out_ready  = 1'b0;
    exp_fc++; exp_pc = 8'h40;
    check("t6_fc", fetch_count, exp_fc);
    check("t6_valid_drop", bus.out_valid, 1'b0);
    check("t6_addr", bus.imem_addr, 8'h40);
    check("t6_rd", bus.imem_rd, 1'b1);
    wait_valid(lat);
    check("t6_next_instr", bus.instruction_out, word_at(8'h40));
    check("t6_next_pc_out", bus.pc_out, 8'h40);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    exp_fc++; exp_pc += 8'd4;

    // ---- randomized fetches with redirects and stalls ----
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 4)) step();
        redirect_valid = 1'b1;
        redirect_pc    = 8'($urandom);
        exp_pc         = redirect_pc & 8'hFC;
        step();
        redirect_valid = 1'b0;
      end
      check("rnd_rd0_addr", bus.imem_addr, exp_pc);
      wait_valid(lat);
      check("rnd_latency", lat, 5);
      check("rnd_instr", bus.instruction_out, word_at(exp_pc));
      check("rnd_pc_out", bus.pc_out, exp_pc);
      held_word = bus.instruction_out;
      repeat ($urandom_range(0, 3)) step();
      check("rnd_stall_valid", bus.out_valid, 1'b1);
      check("rnd_stall_instr", bus.instruction_out, word_at(exp_pc));
      check("rnd_stall_fc", fetch_count, exp_fc);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      exp_fc++; exp_pc += 8'd4;
      check("rnd_fc", fetch_count, exp_fc);
      check("rnd_valid_drop", bus.out_valid, 1'b0);
    end

    // ---- test 5: reset during RD3 ----
    step(); step(); step();
    check("t5_rd3_addr", bus.imem_addr, exp_pc + 8'd3);
    rst_n = 1'b0;
    step();
    exp_fc = 16'h0; exp_pc = 8'h00;
    check("t5_rd", bus.imem_rd, 1'b0);
    check("t5_valid", bus.out_valid, 1'b0);
    check("t5_fc", fetch_count, exp_fc);
    rst_n = 1'b1;
    #1;
    check("t5_addr", bus.imem_addr, 8'h00);
    check("t5_rd_after", bus.imem_rd, 1'b1);
    wait_valid(lat);
    check("t5_latency", lat, 5);
    check("t5_instr", bus.instruction_out, word_at(8'h00));
    check("t5_pc_out", bus.pc_out, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_instr_fetch_unit
